// File: rtl/wspr_symbol_decoder.sv
// WSPR symbol decoder: classifies the generator's per-cycle phase increment into one of
// four tones, emits one symbol strobe per symbol period and flags any frame fault.
module wspr_symbol_decoder #(
   parameter int SYMBOL_CYCLES = 54613333,
   parameter int BASE_FTW      = 0,
   parameter int TONE_FTW      = 79,
   parameter int NUM_SYMBOLS   = 162
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic signed [15:0] iS_amplitude,
   input  logic signed [31:0] iS_phaseAngle,
   output logic [1:0]         o_symbol,
   output logic               o_symbolValid,
   output logic [7:0]         o_symbolIndex,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error
);

   localparam int CW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CYCLE  = CW'(SYMBOL_CYCLES - 1);
   localparam logic [CW-1:0] FIRST_CLASS = CW'(1);
   localparam logic [7:0]    LAST_SYMBOL = 8'(NUM_SYMBOLS - 1);
   localparam logic signed [32:0] TOL    = 33'(TONE_FTW / 4);

   typedef enum logic [1:0] {IDLE, RX, DONE} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cyc_reg, cyc_next;
   logic [7:0]      sym_reg, sym_next;
   logic [1:0]      rec_sym_reg, rec_sym_next;
   logic            rec_valid_reg, rec_valid_next;
   logic [1:0]      symbol_reg, symbol_next;
   logic [7:0]      index_reg, index_next;
   logic            valid_reg, valid_next;
   logic            done_reg, done_next;
   logic            error_reg, error_next;
   logic [31:0]     prev_phase_reg;

   logic [31:0]     delta;
   logic [31:0]     off;
   logic [3:0]      hit;
   logic [1:0]      class_val;
   logic            class_valid;
   logic [1:0]      emit_val;
   logic            carrier;

   assign carrier = (iS_amplitude != 16'sd0);
   assign delta   = $unsigned(iS_phaseAngle) - prev_phase_reg;
   assign off     = delta - 32'(BASE_FTW);

   // One tolerance window per tone; compared in 33 bits so no offset can overflow.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_tone
         localparam logic signed [32:0] K_OFF = 33'(gi * TONE_FTW);
         logic signed [32:0] diff;
         assign diff    = $signed({off[31], off}) - K_OFF;
         assign hit[gi] = (diff >= -TOL) && (diff <= TOL);
      end
   endgenerate

   always_comb begin
      class_val = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (hit[k]) class_val = 2'(k);
      end
   end
   assign class_valid = |hit;

   // With a two-cycle symbol the classifying cycle is also the last one.
   assign emit_val = (cyc_reg == FIRST_CLASS) ? (class_valid ? class_val : 2'd0)
                                              : (rec_valid_reg ? rec_sym_reg : 2'd0);

   always_comb begin
      state_next     = state_reg;
      cyc_next       = cyc_reg;
      sym_next       = sym_reg;
      rec_sym_next   = rec_sym_reg;
      rec_valid_next = rec_valid_reg;
      symbol_next    = symbol_reg;
      index_next     = index_reg;
      valid_next     = 1'b0;
      done_next      = 1'b0;
      error_next     = error_reg;
      case (state_reg)
         IDLE: begin
            if (carrier) begin
               state_next     = RX;
               cyc_next       = FIRST_CLASS;
               sym_next       = 8'd0;
               rec_sym_next   = 2'd0;
               rec_valid_next = 1'b0;
               error_next     = 1'b0;
            end
         end
         RX: begin
            if (!carrier) begin
               state_next = IDLE;
               error_next = 1'b1;
               cyc_next   = '0;
               sym_next   = 8'd0;
            end else begin
               if (cyc_reg == FIRST_CLASS) begin
                  rec_sym_next   = class_val;
                  rec_valid_next = class_valid;
               end else if (cyc_reg != '0) begin
                  if (!class_valid || !rec_valid_reg || (class_val != rec_sym_reg))
                     error_next = 1'b1;
               end
               if (cyc_reg == LAST_CYCLE) begin
                  valid_next  = 1'b1;
                  symbol_next = emit_val;
                  index_next  = sym_reg;
                  cyc_next    = '0;
                  if (sym_reg == LAST_SYMBOL) begin
                     done_next  = 1'b1;
                     state_next = DONE;
                  end else begin
                     sym_next = sym_reg + 8'd1;
                  end
               end else begin
                  cyc_next = cyc_reg + CW'(1);
               end
            end
         end
         DONE: begin
            if (!carrier) begin
               state_next = IDLE;
               sym_next   = 8'd0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg      <= IDLE;
         cyc_reg        <= '0;
         sym_reg        <= 8'd0;
         rec_sym_reg    <= 2'd0;
         rec_valid_reg  <= 1'b0;
         symbol_reg     <= 2'd0;
         index_reg      <= 8'd0;
         valid_reg      <= 1'b0;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
         prev_phase_reg <= 32'd0;
      end else begin
         state_reg      <= state_next;
         cyc_reg        <= cyc_next;
         sym_reg        <= sym_next;
         rec_sym_reg    <= rec_sym_next;
         rec_valid_reg  <= rec_valid_next;
         symbol_reg     <= symbol_next;
         index_reg      <= index_next;
         valid_reg      <= valid_next;
         done_reg       <= done_next;
         error_reg      <= error_next;
         prev_phase_reg <= $unsigned(iS_phaseAngle);
      end
   end

   assign o_symbol      = symbol_reg;
   assign o_symbolValid = valid_reg;
   assign o_symbolIndex = index_reg;
   assign o_busy        = (state_reg == RX);
   assign o_done        = done_reg;
   assign o_error       = error_reg;

endmodule

// File: doc/wspr_symbol_decoder.md
WSPR_SYMBOL_DECODER -- requirements
Module: wspr_symbol_decoder

Interface
REQ-001 SHALL have parameter SYMBOL_CYCLES, default 54613333: i_clk cycles per WSPR symbol (8192/12000 s at 80 MHz).
REQ-002 SHALL have parameter BASE_FTW, default 0: expected per-cycle phase increment of tone 0, in 2^32-per-turn units.
REQ-003 SHALL have parameter TONE_FTW, default 79: phase-increment spacing between adjacent tones (1.4648 Hz at 80 MHz).
REQ-004 SHALL have parameter NUM_SYMBOLS, default 162: symbols per frame.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port iS_amplitude, input, 16-bit signed: generator amplitude; nonzero means transmitting.
REQ-008 SHALL have port iS_phaseAngle, input, 32-bit signed: generator phase accumulator, wrapping modulo 2^32.
REQ-009 SHALL have port o_symbol, output, 2 bits: decoded tone index 0-3.
REQ-010 SHALL have port o_symbolValid, output, 1 bit: one-cycle strobe qualifying o_symbol and o_symbolIndex.
REQ-011 SHALL have port o_symbolIndex, output, 8 bits: position of the emitted symbol in the frame, 0..NUM_SYMBOLS-1.
REQ-012 SHALL have port o_busy, output, 1 bit: high while in RX.
REQ-013 SHALL have port o_done, output, 1 bit: one-cycle strobe on frame completion.
REQ-014 SHALL have port o_error, output, 1 bit: sticky fault flag, cleared at the next frame start.

Function
REQ-015 SHALL implement states IDLE, RX and DONE.
REQ-016 IDLE -> RX on the first cycle with iS_amplitude != 0; that cycle is cycle 0 of symbol 0; o_error clears on that cycle.
REQ-017 SHALL register the previous phase each cycle and form delta = phase - prev_phase as a 32-bit wrapping subtraction; a counter wrap SHALL NOT produce a fault.
REQ-018 SHALL compute off = delta - BASE_FTW (32-bit signed); the cycle's class is k (0..3) when |off - k*TONE_FTW| <= TONE_FTW/4 (integer division), otherwise the class is invalid.
REQ-019 Per-symbol cycle counter runs 0..SYMBOL_CYCLES-1; cycle 0 is excluded from classification because of the tone-change boundary.
REQ-020 The class at cycle 1 is recorded as the symbol value; on any later cycle of the symbol, an invalid class or a class differing from the recorded one SHALL set o_error.
REQ-021 The cycle after cycle SYMBOL_CYCLES-1: o_symbolValid=1 for one cycle, with o_symbol = recorded class (0 if cycle 1 was invalid) and o_symbolIndex = current symbol number.
REQ-022 o_symbol and o_symbolIndex SHALL hold their values until the next strobe.
REQ-023 After emitting symbol NUM_SYMBOLS-1: o_done=1 for one cycle together with that o_symbolValid, and the state SHALL move to DONE.
REQ-024 DONE -> IDLE only on a cycle with iS_amplitude == 0; a continuous carrier SHALL NOT retrigger a frame.
REQ-025 In RX, iS_amplitude == 0 before frame end SHALL set o_error, abort to IDLE with no o_done, and emit no partial symbol.
REQ-026 o_busy = (state == RX).
REQ-027 The symbol counter SHALL be 8 bits and the cycle counter $clog2(SYMBOL_CYCLES) bits; counters SHALL NOT wrap beyond their terminal counts.

Reset
REQ-028 i_reset=1 SHALL force state IDLE and clear all counters and prev_phase, on any cycle including mid-frame.
REQ-029 Reset values: o_symbol=0, o_symbolValid=0, o_symbolIndex=0, o_busy=0, o_done=0, o_error=0.
REQ-030 The first cycle after reset deassertion with amplitude nonzero SHALL start a new frame.

Verification
All scenarios use SYMBOL_CYCLES=16, BASE_FTW=1000, TONE_FTW=100.
REQ-031 Reset: assert i_reset for 3 cycles mid-stream -> all outputs 0, o_busy=0 the cycle after.
REQ-032 Clean frame: amplitude 0x4000, phase stepped per symbol by 1000+100*(n mod 4) -> 162 strobes 16 cycles apart, o_symbol=n mod 4, o_symbolIndex=n, one o_done with index 161, o_error=0.
REQ-033 Wrap: phase starts at 0x7FFFFF00 with tone 3 -> o_symbol=3 through the wrap, o_error=0.
REQ-034 Off-tone: delta=1050 in symbol 5 (tolerance 25) -> o_error=1 and stays 1 until the next frame start.
REQ-035 Abort: amplitude goes to 0 after 10 symbols -> o_error=1, state IDLE, no o_done, last index 9.
REQ-036 Held carrier: amplitude stays nonzero after o_done -> no new strobes until amplitude 0 for >= 1 cycle then nonzero again, after which a new frame starts with index 0.
